// File: rtl/bf_seq_ctrl.sv
// Brainfuck instruction sequencer: PC, tape pointer, loop stack and I/O handshakes.
// Define BF_INPUT_EN to enable the ',' input instruction and the WAIT_IN state.
module bf_seq_ctrl #(
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned RAM_AW      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              step_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [2:0]        opecode,
  input  logic              rom_overrun,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              halted,
  output logic              error
);

  localparam int unsigned SpW    = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IdxW   = $clog2(STACK_DEPTH);
  localparam int unsigned DepthW = ROM_AW + 1;

  localparam logic [2:0] StRun     = 3'd0;
  localparam logic [2:0] StSkip    = 3'd1;
  localparam logic [2:0] StWaitOut = 3'd2;
  localparam logic [2:0] StWaitIn  = 3'd3;
  localparam logic [2:0] StHalt    = 3'd4;
  localparam logic [2:0] StError   = 3'd5;

  localparam logic [2:0] OpRight = 3'd0;
  localparam logic [2:0] OpLeft  = 3'd1;
  localparam logic [2:0] OpInc   = 3'd2;
  localparam logic [2:0] OpDec   = 3'd3;
  localparam logic [2:0] OpOut   = 3'd4;
  localparam logic [2:0] OpIn    = 3'd5;
  localparam logic [2:0] OpLoop  = 3'd6;
  localparam logic [2:0] OpEnd   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ROM_AW-1:0] pc_q, pc_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [DATA_W-1:0] out_char_q, out_char_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic              push_en;

  logic [ROM_AW-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]    sp_dec;
  logic [ROM_AW-1:0] stack_top;
  logic              cell_zero;
  logic              stack_full;
  logic              stack_empty;

  assign sp_dec      = sp_q - 1'b1;
  assign stack_top   = stack_q[sp_dec[IdxW-1:0]];
  assign cell_zero   = (ram_rdata == '0);
  assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

`ifdef BF_INPUT_EN
  logic in_ready_q, in_ready_d;
  assign in_ready = in_ready_q;
`else
  logic unused_in;
  assign unused_in = ^{in_data, in_valid};
  assign in_ready  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ptr_d       = ptr_q;
    sp_d        = sp_q;
    depth_d     = depth_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    error_d     = error_q;
    push_en     = 1'b0;
    ram_we      = 1'b0;
    ram_wdata   = ram_rdata;
`ifdef BF_INPUT_EN
    in_ready_d  = in_ready_q;
`endif

    case (state_q)
      StRun: begin
        if (step_en) begin
          if (rom_overrun) begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
            unique case (opecode)
              OpRight: ptr_d = ptr_q + 1'b1;
              OpLeft:  ptr_d = ptr_q - 1'b1;
              OpInc: begin
                ram_we    = 1'b1;
                ram_wdata = ram_rdata + 1'b1;
              end
              OpDec: begin
                ram_we    = 1'b1;
                ram_wdata = ram_rdata - 1'b1;
              end
              OpOut: begin
                out_char_d  = ram_rdata;
                out_valid_d = 1'b1;
                state_d     = StWaitOut;
              end
              OpIn: begin
`ifdef BF_INPUT_EN
                in_ready_d = 1'b1;
                state_d    = StWaitIn;
`endif
              end
              OpLoop: begin
                if (cell_zero) begin
                  depth_d = DepthW'(1);
                  state_d = StSkip;
                end else if (stack_full) begin
                  pc_d    = pc_q;
                  state_d = StError;
                  error_d = 1'b1;
                end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + 1'b1;
                end
              end
              OpEnd: begin
                if (stack_empty) begin
                  pc_d    = pc_q;
                  state_d = StError;
                  error_d = 1'b1;
                end else if (!cell_zero) begin
                  // Jump to the first instruction of the loop body; entry stays pushed.
                  pc_d = stack_top + 1'b1;
                end else begin
                  sp_d = sp_dec;
                end
              end
            endcase
          end
        end
      end

      StSkip: begin
        if (step_en) begin
          if (rom_overrun) begin
            state_d = StError;
            error_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
            if (opecode == OpLoop) begin
              depth_d = depth_q + 1'b1;
            end else if (opecode == OpEnd) begin
              if (depth_q == DepthW'(1)) begin
                depth_d = '0;
                state_d = StRun;
              end else begin
                depth_d = depth_q - 1'b1;
              end
            end
          end
        end
      end

      StWaitOut: begin
        // Ticks arriving here are dropped; only the handshake moves us on.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StRun;
        end
      end

`ifdef BF_INPUT_EN
      StWaitIn: begin
        if (in_valid && in_ready_q) begin
          ram_we     = 1'b1;
          ram_wdata  = in_data;
          in_ready_d = 1'b0;
          state_d    = StRun;
        end
      end
`endif

      StHalt:  ;
      StError: ;

      default: begin
        state_d = StError;
        error_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StRun;
      pc_q        <= '0;
      ptr_q       <= '0;
      sp_q        <= '0;
      depth_q     <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
`ifdef BF_INPUT_EN
      in_ready_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
`ifdef BF_INPUT_EN
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  // Stack storage needs no reset: the stack pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q[IdxW-1:0]] <= pc_q;
    end
  end

  assign rom_addr  = pc_q;
  assign ram_addr  = ptr_q;
  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bf_seq_ctrl.sv
// Self-checking bench for bf_seq_ctrl: behavioural ROM/RAM models plus an output scoreboard.
module tb_bf_seq_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       step_en;
  logic [7:0] rom_addr;
  logic [2:0] opecode;
  logic       rom_overrun;
  logic [5:0] ram_addr;
  logic [7:0] ram_rdata;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       halted;
  logic       error;

  logic [2:0] rom_mem [256];
  int         prog_len;
  logic [7:0] ram_mem [64];
  int         writes;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];

  bf_seq_ctrl #(
    .ROM_AW(8),
    .RAM_AW(6),
    .DATA_W(8),
    .STACK_DEPTH(8)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .step_en(step_en),
    .rom_addr(rom_addr),
    .opecode(opecode),
    .rom_overrun(rom_overrun),
    .ram_addr(ram_addr),
    .ram_rdata(ram_rdata),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .out_char(out_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .halted(halted),
    .error(error)
  );

  always #5 clk = ~clk;

  assign opecode     = rom_mem[rom_addr];
  assign rom_overrun = (int'(rom_addr) >= prog_len);
  assign ram_rdata   = ram_mem[ram_addr];

  always @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= 8'h00;
      writes <= 0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      writes <= writes + 1;
    end
  end

  // Scoreboard: a transfer seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got char %02h, none expected", out_char);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_char !== e) begin
          bad++;
          $display("FAIL out_char: got %02h want %02h", out_char, e);
        end
      end
    end
  end

  function automatic logic [2:0] enc(input byte c);
    case (c)
      8'h3E:   enc = 3'd0;
      8'h3C:   enc = 3'd1;
      8'h2B:   enc = 3'd2;
      8'h2D:   enc = 3'd3;
      8'h2E:   enc = 3'd4;
      8'h2C:   enc = 3'd5;
      8'h5B:   enc = 3'd6;
      default: enc = 3'd7;
    endcase
  endfunction

  task automatic load(input string s);
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'd0;
    for (int i = 0; i < s.len(); i++) rom_mem[i] = enc(s[i]);
    prog_len = s.len();
  endtask

  task automatic do_reset();
    step_en   = 1'b0;
    out_ready = 1'b1;
    nrst      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    exp_q.delete();
  endtask

  task automatic run_until_done(input int budget);
    bit done = 0;
    step_en = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (halted || error) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout: halted=%0b error=%0b after %0d cycles", halted, error, budget);
    end
    @(posedge clk);
    #1 step_en = 1'b0;
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL out_missing: %0d expected chars not sent", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    load("+");
    do_reset();
    @(negedge clk);
    total++; if (rom_addr !== 8'd0)  begin bad++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    total++; if (ram_addr !== 6'd0)  begin bad++; $display("FAIL rst_ram_addr: got %0d want 0", ram_addr); end
    total++; if ({out_valid, out_char} !== 9'd0) begin
      bad++; $display("FAIL rst_out: got v=%0b c=%02h want 0/00", out_valid, out_char);
    end
    total++; if ({in_ready, halted, error, ram_we} !== 4'b0000) begin
      bad++; $display("FAIL rst_flags: got %04b want 0000", {in_ready, halted, error, ram_we});
    end
  endtask

  task automatic test_basic();
    load("+++.");
    do_reset();
    exp_q.push_back(8'h03);
    run_until_done(50);
    total++; if (ram_mem[0] !== 8'h03) begin bad++; $display("FAIL basic_ram0: got %02h want 03", ram_mem[0]); end
    total++; if (rom_addr !== 8'd4) begin bad++; $display("FAIL basic_pc: got %0d want 4", rom_addr); end
    total++; if (writes !== 3) begin bad++; $display("FAIL basic_writes: got %0d want 3", writes); end
    total++; if ({halted, error} !== 2'b10) begin bad++; $display("FAIL basic_halt: got %02b want 10", {halted, error}); end
  endtask

  task automatic test_wrap();
    load("<-");
    do_reset();
    run_until_done(20);
    total++; if (ram_addr !== 6'd63) begin bad++; $display("FAIL wrap_ptr: got %0d want 63", ram_addr); end
    total++; if (ram_mem[63] !== 8'hFF) begin bad++; $display("FAIL wrap_cell: got %02h want ff", ram_mem[63]); end
    total++; if (writes !== 1) begin bad++; $display("FAIL wrap_writes: got %0d want 1", writes); end
  endtask

  task automatic test_loop();
    load("++[>+<-]>.");
    do_reset();
    exp_q.push_back(8'h02);
    run_until_done(100);
    total++; if (ram_mem[1] !== 8'h02) begin bad++; $display("FAIL loop_ram1: got %02h want 02", ram_mem[1]); end
    total++; if (ram_mem[0] !== 8'h00) begin bad++; $display("FAIL loop_ram0: got %02h want 00", ram_mem[0]); end
    total++; if ({halted, error} !== 2'b10) begin bad++; $display("FAIL loop_halt: got %02b want 10", {halted, error}); end
  endtask

  task automatic test_skip();
    load("[[+]+].");
    do_reset();
    exp_q.push_back(8'h00);
    run_until_done(50);
    total++; if (writes !== 0) begin bad++; $display("FAIL skip_writes: got %0d want 0", writes); end
    total++; if (rom_addr !== 8'd7) begin bad++; $display("FAIL skip_pc: got %0d want 7", rom_addr); end
    total++; if ({halted, error} !== 2'b10) begin bad++; $display("FAIL skip_halt: got %02b want 10", {halted, error}); end
  endtask

  task automatic test_stall();
    bit seen = 0;
    load("+++++.");
    do_reset();
    exp_q.push_back(8'h05);
    out_ready = 1'b0;
    step_en   = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_valid_timeout: out_valid=%0b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_char, rom_addr} !== {1'b1, 8'h05, 8'd6}) begin
        bad++;
        $display("FAIL stall_hold: got v=%0b c=%02h pc=%0d want 1/05/6", out_valid, out_char, rom_addr);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    run_until_done(20);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_step_gating();
    load("+++.");
    do_reset();
    exp_q.push_back(8'h03);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 step_en = 1'b1;
      @(posedge clk);
      #1 step_en = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (rom_addr !== 8'(k)) begin bad++; $display("FAIL gate_pc: got %0d want %0d", rom_addr, k); end
    end
    run_until_done(20);
    total++; if (ram_mem[0] !== 8'h03) begin bad++; $display("FAIL gate_ram0: got %02h want 03", ram_mem[0]); end
  endtask

  task automatic test_overflow();
    logic [7:0] pc_at_err;
    load("+[[[[[[[[[");
    do_reset();
    run_until_done(50);
    total++; if ({halted, error} !== 2'b01) begin bad++; $display("FAIL ovf_flags: got %02b want 01", {halted, error}); end
    pc_at_err = rom_addr;
    step_en = 1'b1;
    repeat (10) @(negedge clk);
    step_en = 1'b0;
    total++; if (writes !== 1) begin bad++; $display("FAIL ovf_writes: got %0d want 1", writes); end
    total++; if ({out_valid, rom_addr} !== {1'b0, pc_at_err}) begin
      bad++; $display("FAIL ovf_frozen: got v=%0b pc=%0d want 0/%0d", out_valid, rom_addr, pc_at_err);
    end
  endtask

  task automatic test_unmatched();
    load("]");
    do_reset();
    run_until_done(20);
    total++; if ({halted, error} !== 2'b01) begin bad++; $display("FAIL unmatched_flags: got %02b want 01", {halted, error}); end
    total++; if (writes !== 0) begin bad++; $display("FAIL unmatched_writes: got %0d want 0", writes); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    load("+.");
    do_reset();
    out_ready = 1'b0;
    step_en   = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++;
    if (!seen || out_char !== 8'h01) begin
      bad++; $display("FAIL midrst_pending: got v=%0b c=%02h want 1/01", out_valid, out_char);
    end
    @(posedge clk);
    #1 nrst = 1'b0;
    step_en = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_char, rom_addr, ram_addr, halted, error, in_ready, ram_we} !== 28'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got v=%0b c=%02h pc=%0d ptr=%0d h=%0b e=%0b want all 0",
               out_valid, out_char, rom_addr, ram_addr, halted, error);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    nrst      = 1'b0;
    step_en   = 1'b0;
    out_ready = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_loop();
    test_skip();
    test_stall();
    test_step_gating();
    test_overflow();
    test_unmatched();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
